// File: rtl/prog_mem_pkg.sv
// Shared types, constants and helpers for the parametrised instruction memory.
package prog_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } pm_state_e;

    localparam logic [31:0]  PM_NOP      = 32'h0000_0013;
    localparam int unsigned  PM_MAX_WAIT = 4;
    localparam int unsigned  PM_CNT_W    = $clog2(PM_MAX_WAIT);

    // Misaligned, or any byte-address bit above the word-index field set.
    function automatic logic pm_addr_err(input logic [31:0] addr, input int unsigned addr_w);
        return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 32'd2)) != 32'd0);
    endfunction

endpackage

// File: rtl/prog_mem_if.sv
// Fetch handshake between the core's fetch stage (master) and prog_mem (slave).
interface prog_mem_if #(
    parameter int unsigned DATA_W = 32
) ();

    logic              req;
    logic [31:0]       addr;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rvalid,
        input  rdata,
        input  err
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rvalid,
        output rdata,
        output err
    );

endinterface

// File: rtl/prog_mem_array.sv
// Program storage: synchronous write, combinational read, filled with INIT at time zero.
module prog_mem_array #(
    parameter int unsigned       ADDR_W = 8,
    parameter int unsigned       DATA_W = 32,
    parameter logic [DATA_W-1:0] INIT   = '0
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // Not touched by reset: a loaded program survives a core reset.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: INIT};

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_mem.sv
// Instruction memory with req/ready/rvalid fetch handshake, fixed read latency and a program-load port.
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int unsigned       ADDR_W = 8,
    parameter int unsigned       DATA_W = 32,
    parameter int unsigned       WAIT   = 1,
    parameter logic [DATA_W-1:0] NOP    = DATA_W'(PM_NOP)
) (
    input  logic              clk,
    input  logic              reset_n,
    prog_mem_if.slave         bus,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_wdata
);

    localparam int unsigned      CNT_W    = PM_CNT_W;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT - 1);

    if (WAIT < 1 || WAIT > PM_MAX_WAIT || DATA_W < 32) begin : g_param_check
        $fatal(1, "prog_mem: WAIT must be in 1..%0d and DATA_W >= 32", PM_MAX_WAIT);
    end

    pm_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ready_q;
    logic              rvalid_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic              pend_err_q;
    logic [DATA_W-1:0] pend_data_q;

    logic              accept;
    logic              fetch_err_d;
    logic [DATA_W-1:0] fetch_data_d;
    logic [ADDR_W-1:0] rd_idx;
    logic [DATA_W-1:0] arr_rdata;

    assign rd_idx = bus.addr[ADDR_W+1:2];

    prog_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .INIT   (NOP)
    ) u_array (
        .clk     (clk),
        .we_i    (prog_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_wdata),
        .raddr_i (rd_idx),
        .rdata_o (arr_rdata)
    );

    // Word is taken in the accept cycle, so a same-edge write is not seen (read-first).
    always_comb begin
        accept       = bus.req && ready_q;
        fetch_err_d  = pm_addr_err(bus.addr, ADDR_W);
        fetch_data_d = fetch_err_d ? NOP : arr_rdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= NOP;
            pend_err_q  <= 1'b0;
            pend_data_q <= NOP;
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                IDLE, RESP: begin
                    if (accept) begin
                        pend_data_q <= fetch_data_d;
                        pend_err_q  <= fetch_err_d;
                        cnt_q       <= CNT_LOAD;
                        // Single-cycle latency skips BUSY and presents the word straight away.
                        if (WAIT == 1) begin
                            state_q  <= RESP;
                            ready_q  <= 1'b1;
                            rvalid_q <= 1'b1;
                            rdata_q  <= fetch_data_d;
                            err_q    <= fetch_err_d;
                        end else begin
                            state_q <= BUSY;
                            ready_q <= 1'b0;
                        end
                    end else begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_q    <= '0;
                        state_q  <= RESP;
                        ready_q  <= 1'b1;
                        rvalid_q <= 1'b1;
                        rdata_q  <= pend_data_q;
                        err_q    <= pend_err_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready  = ready_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;

    a_ready_moore: assert property (@(posedge clk) disable iff (!reset_n)
        ready_q == (state_q != BUSY));
    a_rvalid_ready: assert property (@(posedge clk) disable iff (!reset_n)
        rvalid_q |-> ready_q);
    a_cnt_range: assert property (@(posedge clk) disable iff (!reset_n)
        cnt_q <= CNT_LOAD);

endmodule
